// File: rtl/addsub_sequencer.sv
// addsub_sequencer: byte-serial add/subtract of two 8*NBYTES-bit operands.
// One 8-bit carry-lookahead slice is reused for every byte. The carry passes
// from one byte to the next only through a carry register, so an operation
// takes NBYTES cycles in RUN followed by one DONE cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands and sub are latched on acceptance
// RUN   | one byte per cycle through the CLA slice, LSB byte first
// DONE  | done pulses for one cycle; result/cout/ovf then hold in IDLE
module addsub_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic                  r_carry;
  logic                  r_sub;
  logic [8*NBYTES-1:0]   r_a;
  logic [8*NBYTES-1:0]   r_b;
  logic [8*NBYTES-1:0]   r_result;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cout;
  logic                  r_ovf;

  logic [7:0]            w_x;
  logic [7:0]            w_y;
  logic [7:0]            w_g;
  logic [7:0]            w_p;
  logic [8:0]            w_c;
  logic [7:0]            w_sum;

  assign w_x = r_a[8*r_idx +: 8];

  // CLA slice: every carry is a flat sum-of-products of g, p and the carry-in.
  always_comb begin
    logic v_t;
    w_y   = r_b[8*r_idx +: 8] ^ {8{r_sub}};
    w_g   = w_x & w_y;
    w_p   = w_x ^ w_y;
    w_c   = '0;
    w_c[0] = r_carry;
    for (int i = 0; i < 8; i++) begin
      v_t = r_carry;
      for (int k = 0; k <= i; k++) begin
        v_t = v_t & w_p[k];
      end
      w_c[i+1] = v_t;
      for (int j = 0; j <= i; j++) begin
        v_t = w_g[j];
        for (int k = j + 1; k <= i; k++) begin
          v_t = v_t & w_p[k];
        end
        w_c[i+1] = w_c[i+1] | v_t;
      end
    end
    w_sum = w_p ^ w_c[7:0];
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_sub    <= sub;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= sub;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_result[8*r_idx +: 8] <= w_sum;
          r_carry <= w_c[8];
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_cout  <= w_c[8];
            r_ovf   <= w_c[7] ^ w_c[8];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Bench for addsub_sequencer (NBYTES=4): directed cases plus random operands
// checked against an arithmetic reference model.
module tb_addsub_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk;
  logic          rst;
  logic          start;
  logic          sub;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          cout;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  addsub_sequencer #(.NBYTES(NB)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts an operation at the next edge, watches done/busy for a bounded
  // number of cycles and compares against the arithmetic model.
  // Called #1 after a rising edge (or at time zero phase away from an edge).
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tsub, input logic pulse_busy);
    logic [W-1:0] exp_res;
    logic         exp_cout;
    logic         exp_ovf;
    longint       sa, sb, sr;
    int           first;
    int           npulse;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb_));
    if (tsub) begin
      exp_res  = ta - tb_;
      exp_cout = (ta >= tb_);
      sr       = sa - sb;
    end else begin
      exp_res  = ta + tb_;
      exp_cout = ((longint'(ta) + longint'(tb_)) >= (longint'(1) << W));
      sr       = sa + sb;
    end
    exp_ovf = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));

    a = ta; b = tb_; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ":busy_after_start"}, 64'(busy), 64'd1);
    chk({tag, ":done_after_start"}, 64'(done), 64'd0);
    first = -1;
    npulse = 0;
    for (int i = 1; i <= NB + 3; i++) begin
      if (pulse_busy && i == 1) begin
        a = ~ta; b = ~tb_; sub = ~tsub; start = 1'b1;
      end
      if (pulse_busy && i == 3) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
    start = 1'b0;
    chk({tag, ":done_cycle"}, 64'(first), 64'(NB));
    chk({tag, ":done_pulses"}, 64'(npulse), 64'd1);
    chk({tag, ":busy_end"}, 64'(busy), 64'd0);
    chk({tag, ":result"}, 64'(result), 64'(exp_res));
    chk({tag, ":cout"}, 64'(cout), 64'(exp_cout));
    chk({tag, ":ovf"}, 64'(ovf), 64'(exp_ovf));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset:busy", 64'(busy), 64'd0);
    chk("reset:done", 64'(done), 64'd0);
    chk("reset:result", 64'(result), 64'd0);
    chk("reset:cout", 64'(cout), 64'd0);
    chk("reset:ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    run_op("add2p5", 32'h0000_0002, 32'h0000_0005, 1'b0, 1'b0);
    chk("add2p5:const", 64'(result), 64'h0000_0007);

    run_op("addFFp1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    chk("addFFp1:const", 64'(result), 64'h0000_0100);

    run_op("addwrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("addwrap:const", 64'(result), 64'h0);
    chk("addwrap:cout_const", 64'(cout), 64'd1);

    run_op("addovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("addovf:const", 64'(result), 64'h8000_0000);
    chk("addovf:ovf_const", 64'(ovf), 64'd1);

    run_op("subovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    chk("subovf:const", 64'(result), 64'h7FFF_FFFF);
    chk("subovf:ovf_const", 64'(ovf), 64'd1);

    run_op("sub7m5", 32'd7, 32'd5, 1'b1, 1'b0);
    chk("sub7m5:const", 64'(result), 64'h0000_0002);
    chk("sub7m5:cout_const", 64'(cout), 64'd1);

    run_op("sub5m7", 32'd5, 32'd7, 1'b1, 1'b0);
    chk("sub5m7:const", 64'(result), 64'hFFFF_FFFE);
    chk("sub5m7:cout_const", 64'(cout), 64'd0);

    // start with new operands while busy must be ignored
    run_op("busyign", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    chk("busyign:const", 64'(result), 64'h2345_6789);

    // rst has priority over start
    rst = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9; sub = 1'b0;
    @(posedge clk); #1;
    chk("rstprio:busy", 64'(busy), 64'd0);
    chk("rstprio:result", 64'(result), 64'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rstprio:idle", 64'(busy), 64'd0);

    // reset during the second RUN cycle abandons the operation
    a = 32'h0101_0101; b = 32'h0202_0202; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("midrst:done_before", 64'(done), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst:busy", 64'(busy), 64'd0);
    chk("midrst:result", 64'(result), 64'd0);
    chk("midrst:done", 64'(done), 64'd0);
    rst = 1'b0;
    run_op("afterrst", 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0);
    chk("afterrst:const", 64'(result), 64'h0000_5555);

    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (n % 5 == 0) rb = ra;
      run_op("rand", ra, rb, rs, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_sequencer.md
ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract (a - b); sampled with start.
REQ-006 The block SHALL have port a, input, 8*NBYTES bits: operand A; sampled with start.
REQ-007 The block SHALL have port b, input, 8*NBYTES bits: operand B; sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (RUN or DONE).
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have port result, output, 8*NBYTES bits: sum or difference.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of the MSB (for subtract, 1 = no borrow).
REQ-012 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 The block SHALL contain exactly one 8-bit carry-lookahead add/sub slice, with generate g = x & y' and propagate p = x ^ y', where y' = y ^ {8{sub}}, and all internal carries computed in lookahead form (no ripple); the slice SHALL be reused across bytes.
REQ-014 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL, at that edge, latch a, b and sub, clear result, set byte index to 0, set the carry register to sub, and go to RUN.
REQ-016 IDLE with start=0 SHALL remain in IDLE.
REQ-017 Each RUN cycle SHALL process byte[idx]: result byte[idx] <= slice sum of a byte[idx], b byte[idx] and the carry register; the carry register <= slice carry-out; idx increments.
REQ-018 When idx = NBYTES-1, RUN SHALL capture cout from the slice carry-out and ovf = (carry into bit 7) XOR (carry out of bit 7) of that byte, then go to DONE.
REQ-019 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-020 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+NBYTES, i.e. NBYTES+1 cycles after the start edge.
REQ-021 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-022 start SHALL be ignored while busy=1; the latched operands SHALL be unaffected by input changes after acceptance.
REQ-023 result, cout and ovf SHALL hold their values from DONE until the next accepted start.
REQ-024 Arithmetic SHALL be modulo 2^(8*NBYTES); the carry SHALL propagate between bytes only through the carry register.

Reset
REQ-025 rst=1 SHALL, at the clock edge, force state IDLE, idx=0, carry register=0, busy=0, done=0, result=0, cout=0 and ovf=0, regardless of state.
REQ-026 rst SHALL take priority over start in the same cycle.
REQ-027 A reset asserted mid-operation SHALL abandon the operation with no done pulse; a start in the first cycle after rst deasserts SHALL be accepted normally.

Verification (NBYTES=4)
REQ-028 The bench SHALL check: add 0x00000002 + 0x00000005 -> result 0x00000007, cout 0, ovf 0, done exactly 5 cycles after the start edge and high for 1 cycle.
REQ-029 The bench SHALL check the carry chain: 0x000000FF + 0x00000001 -> 0x00000100; 0xFFFFFFFF + 0x00000001 -> 0x00000000, cout 1, ovf 0.
REQ-030 The bench SHALL check signed overflow: 0x7FFFFFFF + 0x00000001 -> 0x80000000, cout 0, ovf 1; subtract 0x80000000 - 0x00000001 -> 0x7FFFFFFF, ovf 1.
REQ-031 The bench SHALL check subtract: 7 - 5 -> 0x00000002, cout 1; 5 - 7 -> 0xFFFFFFFE, cout 0, ovf 0.
REQ-032 The bench SHALL check that start with new operands pulsed while busy is ignored: the first result is unchanged and no second done pulse occurs.
REQ-033 The bench SHALL check that rst asserted during the 2nd RUN cycle gives busy=0 and result=0 on the next cycle with no done pulse, and that a following add completes correctly.
